// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Bundles every signal exchanged between the hazard sequencer and the
// five-stage MIPS pipeline it governs.
//
// Modports:
//   master : the hazard sequencer. Observes decode/execute/memory status and
//            drives the pipeline-register enables, flush strobes and status.
//   slave  : the pipeline datapath. Supplies decode/execute/memory status and
//            consumes the enables and strobes.
//
// Signals (pipeline -> sequencer):
//   id_opcode[5:0]    IF/ID instruction[31:26]
//   id_rs[4:0]        IF/ID instruction[25:21]
//   id_rt[4:0]        IF/ID instruction[20:16]
//   id_uses_rt        decode-stage instruction reads rt
//   ex_mem_read       ID/EX MemRead
//   ex_rt[4:0]        ID/EX rt (load destination)
//   mem_branch_taken  PCSrc from the memory stage
//   dmem_busy         data memory has not finished the MEM-stage access
//
// Signals (sequencer -> pipeline):
//   pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write
//                     pipeline-register load enables
//   if_id_flush       load a NOP into IF/ID
//   id_ex_bubble      zero WB/M/EX control fields entering ID/EX
//   ex_mem_flush      zero WB/M control fields entering EX/MEM
//   halted            pipeline stopped by a halt instruction
//   mem_timeout       sticky data-memory timeout flag
//   state[2:0]        sequencer state (RUN=0 STALL=1 WAIT=2 DRAIN=3 HALTED=4)
//   stall_count, flush_count, wait_count [15:0]   statistics
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pipeline_hazard_ctrl_if;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        mem_branch_taken;
    logic        dmem_busy;

    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        mem_wb_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic        halted;
    logic        mem_timeout;
    logic [2:0]  state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic [15:0] wait_count;

    modport master (
        input  id_opcode, id_rs, id_rt, id_uses_rt,
        input  ex_mem_read, ex_rt, mem_branch_taken, dmem_busy,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        output if_id_flush, id_ex_bubble, ex_mem_flush,
        output halted, mem_timeout, state,
        output stall_count, flush_count, wait_count
    );

    modport slave (
        output id_opcode, id_rs, id_rt, id_uses_rt,
        output ex_mem_read, ex_rt, mem_branch_taken, dmem_busy,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        input  if_id_flush, id_ex_bubble, ex_mem_flush,
        input  halted, mem_timeout, state,
        input  stall_count, flush_count, wait_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall / flush / halt sequencer for a five-stage MIPS pipeline
// (fetch, decode, execute, memory, writeBack). Each cycle it classifies the
// pipeline condition with the fixed priority
//     data-memory busy > taken branch > halt decode > load-use
// and drives the per-stage register enables and flush/bubble strobes
// combinationally, so the pipeline registers consume them on the same edge.
//
// Ports:
//   clk    pipeline clock, state advances on posedge
//   rst_n  asynchronous active-low reset; while low every enable and strobe
//          is forced to 0 and state/counters/flags are cleared
//   hz     pipeline_hazard_ctrl_if.master (see the interface file for the
//          signal list)
//
// Parameters:
//   WAIT_MAX      busy cycles (counted from the first one) after which a
//                 stuck data memory is declared timed out (>= 2)
//   DRAIN_CYCLES  cycles allowed for older instructions to retire after a
//                 halt decodes (>= 1)
//   HALT_OPCODE   opcode of the halt instruction
//
// Optional feature, macro HAZARD_STATS_EN:
//   defined   -> stall_count / flush_count / wait_count count load-use
//                bubbles, taken-branch flushes and busy-frozen cycles
//                (16-bit, saturating)
//   undefined -> counter logic is absent and the three outputs read 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_MAX     = 16,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [5:0]  HALT_OPCODE  = 6'h3F
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.master hz
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_STALL  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // The WAIT counter holds the number of busy cycles already frozen; the
    // cycle that would make it reach WAIT_MAX is the timeout cycle.
    localparam logic [15:0] WAIT_LAST  = 16'(WAIT_MAX - 1);
    localparam logic [15:0] DRAIN_INIT = 16'(DRAIN_CYCLES);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] sat_dec(input logic [15:0] v);
        return (v == 16'h0000) ? v : v - 16'd1;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;        // WAIT busy count or DRAIN countdown
    logic        timeout_q, timeout_d;

    logic load_use;
    logic run_like;
    logic is_halt_op;
    logic ev_busy;
    logic ev_timeout;
    logic ev_freeze;
    logic ev_taken;
    logic ev_halt;
    logic ev_stall;
    logic ev_drain;

    // -------------------------------------------------------------------------
    // Event classification (priority resolved here, shared by both FSM combs)
    // -------------------------------------------------------------------------
    assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // WAIT with busy low is evaluated exactly like RUN; STALL differs only in
    // masking load_use so a load-use hazard produces a single bubble.
    assign run_like   = (state_q == ST_RUN) || (state_q == ST_STALL) ||
                        (state_q == ST_WAIT);
    assign is_halt_op = (hz.id_opcode == HALT_OPCODE);

    assign ev_busy    = hz.dmem_busy && (state_q != ST_HALTED);
    assign ev_timeout = hz.dmem_busy && (state_q == ST_WAIT) && (cnt_q >= WAIT_LAST);
    assign ev_freeze  = ev_busy && !ev_timeout;

    // A branch resolved taken while draining means the halt was fetched on
    // the wrong path, so DRAIN also honours it.
    assign ev_taken   = !ev_busy && hz.mem_branch_taken &&
                        (run_like || (state_q == ST_DRAIN));
    assign ev_halt    = !ev_busy && !hz.mem_branch_taken && run_like && is_halt_op;
    assign ev_stall   = !ev_busy && !hz.mem_branch_taken && !is_halt_op &&
                        run_like && (state_q != ST_STALL) && load_use;
    assign ev_drain   = !ev_busy && !hz.mem_branch_taken && (state_q == ST_DRAIN);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = ST_RUN;
        cnt_d     = 16'd0;
        timeout_d = timeout_q || ev_timeout;

        if (state_q == ST_HALTED) begin
            state_d = ST_HALTED;
            cnt_d   = cnt_q;
        end else if (ev_freeze) begin
            if (state_q == ST_DRAIN) begin
                // Drain countdown only advances on cycles that actually retire.
                state_d = ST_DRAIN;
                cnt_d   = cnt_q;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = (state_q == ST_WAIT) ? sat_inc(cnt_q) : 16'd1;
            end
        end else if (ev_timeout) begin
            state_d = ST_RUN;
        end else if (ev_taken) begin
            state_d = ST_RUN;
        end else if (ev_halt) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_INIT;
        end else if (ev_stall) begin
            state_d = ST_STALL;
        end else if (ev_drain) begin
            cnt_d   = sat_dec(cnt_q);
            state_d = (cnt_q <= 16'd1) ? ST_HALTED : ST_DRAIN;
        end else begin
            state_d = ST_RUN;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.id_ex_write  = 1'b1;
        hz.ex_mem_write = 1'b1;
        hz.mem_wb_write = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.halted       = 1'b0;

        if (!rst_n || (state_q == ST_HALTED) || ev_freeze) begin
            // Reset, halt and busy memory all hold every pipeline register.
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_write  = 1'b0;
            hz.ex_mem_write = 1'b0;
            hz.mem_wb_write = 1'b0;
            hz.halted       = rst_n && (state_q == ST_HALTED);
        end else if (ev_timeout) begin
            // Give up on the memory and let the pipeline advance.
        end else if (ev_taken) begin
            // Squash the three younger instructions in IF/ID, ID/EX, EX/MEM.
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
            hz.ex_mem_flush = 1'b1;
        end else if (ev_halt || (state_q == ST_DRAIN)) begin
            // Stop fetching and keep IF/ID empty while older work retires.
            hz.pc_write     = 1'b0;
            hz.if_id_flush  = 1'b1;
        end else if (ev_stall) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end
    end

    assign hz.state       = state_q;
    assign hz.mem_timeout = timeout_q;

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic [15:0] wait_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            wait_cnt_q  <= 16'd0;
        end else begin
            if (ev_stall)  stall_cnt_q <= sat_inc(stall_cnt_q);
            if (ev_taken)  flush_cnt_q <= sat_inc(flush_cnt_q);
            if (ev_freeze) wait_cnt_q  <= sat_inc(wait_cnt_q);
        end
    end

    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
    assign hz.wait_count  = wait_cnt_q;
`else
    assign hz.stall_count = 16'h0000;
    assign hz.flush_count = 16'h0000;
    assign hz.wait_count  = 16'h0000;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/halt sequencer for the five-stage MIPS pipeline (fetch, decode, execute, memory, writeBack). Watches the decode-stage instruction, the ID/EX load destination, the memory-stage branch decision and a data-memory busy handshake. Drives per-stage pipeline-register write enables and flush/bubble strobes so that load-use hazards, taken branches, slow memory and program halt are handled without software NOPs.

## Interface
Parameters:
- WAIT_MAX, 16: busy cycles tolerated in WAIT before timeout (≥2).
- DRAIN_CYCLES, 4: cycles allowed for older instructions to retire after a halt decodes.
- HALT_OPCODE, 6'h3F: opcode of the halt instruction.

Ports:
- clk  in  1  pipeline clock; state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- id_opcode  in  6  IF/ID instruction[31:26].
- id_rs  in  5  IF/ID instruction[25:21].
- id_rt  in  5  IF/ID instruction[20:16].
- id_uses_rt  in  1  decode-stage instruction reads rt (R-type, beq, sw).
- ex_mem_read  in  1  ID/EX MemRead bit.
- ex_rt  in  5  ID/EX rt (load destination).
- mem_branch_taken  in  1  PCSrc from memory stage.
- dmem_busy  in  1  data memory not ready; MEM-stage operation incomplete.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  pipeline-register load enables.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  zero WB/M/EX control fields entering ID/EX.
- ex_mem_flush  out  1  zero WB/M fields entering EX/MEM.
- halted  out  1  pipeline stopped by halt.
- mem_timeout  out  1  sticky: WAIT exceeded WAIT_MAX.
- state  out  3  RUN=0, STALL=1, WAIT=2, DRAIN=3, HALTED=4.
- stall_count, flush_count, wait_count  out  16 each  statistics (see Configuration).

## Operation
- load_use = ex_mem_read & (ex_rt≠0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Default (no event): all five writes 1, all flush/bubble 0.
- Priority per cycle: dmem_busy > mem_branch_taken > halt decode > load_use.
- RUN:
  - busy: all writes 0, no flush → WAIT, wait counter=1.
  - taken: writes 1; if_id_flush, id_ex_bubble, ex_mem_flush = 1 → RUN.
  - id_opcode==HALT_OPCODE: pc_write=0, if_id_flush=1 → DRAIN, drain counter=DRAIN_CYCLES.
  - load_use: pc_write=0, if_id_write=0, id_ex_bubble=1 → STALL.
- STALL: as RUN with load_use masked; → RUN (or WAIT on busy, which keeps priority).
- WAIT: busy high → all writes 0, counter+1; counter==WAIT_MAX → set mem_timeout, outputs as default, → RUN. Busy low → evaluate as RUN this cycle (branch/halt/load_use honoured), next state per RUN rules.
- DRAIN: pc_write=0, if_id_flush=1, other writes 1; busy freezes all writes, counter holds; otherwise counter−1, at 0 → HALTED. mem_branch_taken in DRAIN: halt was wrong-path, apply RUN taken response, → RUN.
- HALTED: all writes 0, halted=1; exit only via reset.
- Counters 16-bit, saturating at 0xFFFF.

## Timing
- Strobes/enables combinational from state + inputs; consumed by pipeline registers at the same posedge. State, counters, mem_timeout registered.
- rst_n low (async, any state, mid-WAIT/DRAIN included): state=RUN, internal counters 0, mem_timeout=0, statistics 0; all writes 0, all flushes 0, halted=0 while asserted. First posedge after release behaves as RUN.
- Load-use: exactly one bubble cycle. Taken branch: one flush cycle, three instructions squashed. Halt to halted: DRAIN_CYCLES+1 non-busy cycles.
- Simultaneous busy+taken: freeze; branch reapplied when busy drops (MEM inputs held).

## Configuration
- HAZARD_STATS_EN defined: stall_count +1 per load_use bubble, flush_count +1 per taken-branch flush, wait_count +1 per busy-frozen cycle; reset to 0.
- Undefined: counter logic absent; the three ports tied to 16'h0. Control behaviour identical.

## Test plan
- lw $t1 in EX (ex_mem_read=1, ex_rt=9), ID add reads rs=9 → one cycle pc_write=0, if_id_write=0, id_ex_bubble=1, state=1; next cycle RUN, no second bubble; ex_rt=0 → no stall.
- mem_branch_taken=1 pulse → single cycle with if_id_flush=id_ex_bubble=ex_mem_flush=1, pc_write=1.
- dmem_busy high 3 cycles with taken branch and load_use present → 3 frozen cycles (state=2), then branch flush on release; wait_count=3 with HAZARD_STATS_EN.
- dmem_busy held 20 cycles, WAIT_MAX=16 → mem_timeout=1 at 16th cycle, state returns 0, flag sticks until rst_n.
- Opcode 0x3F decoded → DRAIN 4 cycles, then halted=1, all writes 0; repeat with taken branch at DRAIN cycle 2 → flush, state=0, halted stays 0.
- rst_n asserted mid-DRAIN (asynchronous, between edges) → immediately state=0, all outputs reset values; normal run after release.
